sram_arbiter: RTL

Two-port arbiter sharing the board's single 8-bit asynchronous SRAM (20-bit address, 1 MB space) between the video fetch path and the CPU/cache path. It sits between the system core and the SRAM pins and drives address, data and write-enable. Video reads have priority; a streak limiter guarantees the CPU a slot. The top level builds the tri-state `SRAM_D` bus from `sram_dout`/`sram_dout_en`/`sram_din`.

---
 rtl/sram_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// Two-port arbiter for the shared 8-bit async SRAM: video reads take priority,
// a streak limiter guarantees the CPU a slot after VID_MAX_CONSEC video grants.
module sram_arbiter #(
  parameter int ACCESS_CYCLES  = 2,
  parameter int VID_MAX_CONSEC = 4
) (
  input  logic        clk_vga,
  input  logic        rst,
  input  logic        vid_req,
  input  logic [19:0] vid_addr,
  output logic        vid_ack,
  output logic [7:0]  vid_rdata,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [19:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic [19:0] sram_addr,
  output logic [7:0]  sram_dout,
  output logic        sram_dout_en,
  input  logic [7:0]  sram_din,
  output logic        sram_we_n,
  output logic        busy
);

  localparam logic [3:0] CNT_LAST    = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] CNT_WE_LAST = 4'(ACCESS_CYCLES - 2);
  localparam logic [3:0] STREAK_MAX  = 4'(VID_MAX_CONSEC);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  streak_q, streak_d;
  logic        owner_cpu_q, owner_cpu_d;
  logic [19:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  vid_rdata_q, vid_rdata_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic        grant_vid;
  logic        grant_cpu;

  // Arbitration: video wins a tie unless it has already used up its streak.
  always_comb begin
    grant_vid = 1'b0;
    grant_cpu = 1'b0;
    if (state_q == ST_IDLE) begin
      if (vid_req && (!cpu_req || (streak_q != STREAK_MAX))) begin
        grant_vid = 1'b1;
      end else if (cpu_req) begin
        grant_cpu = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    streak_d    = streak_q;
    owner_cpu_d = owner_cpu_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    vid_rdata_d = vid_rdata_q;
    cpu_rdata_d = cpu_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_vid) begin
          owner_cpu_d = 1'b0;
          addr_d      = vid_addr;
          we_d        = 1'b0;
          state_d     = ST_ACCESS;
          cnt_d       = 4'd0;
          if (cpu_req) begin
            streak_d = (streak_q >= STREAK_MAX) ? STREAK_MAX : streak_q + 4'd1;
          end else begin
            streak_d = 4'd0;
          end
        end else if (grant_cpu) begin
          owner_cpu_d = 1'b1;
          addr_d      = cpu_addr;
          we_d        = cpu_we;
          wdata_d     = cpu_wdata;
          state_d     = ST_ACCESS;
          cnt_d       = 4'd0;
          streak_d    = 4'd0;
        end
      end

      ST_ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          cnt_d   = 4'd0;
          // Read data lands on the same edge that raises the owner's ack.
          if (!we_q) begin
            if (owner_cpu_q) begin
              cpu_rdata_d = sram_din;
            end else begin
              vid_rdata_d = sram_din;
            end
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      streak_q    <= 4'd0;
      owner_cpu_q <= 1'b0;
      addr_q      <= 20'd0;
      we_q        <= 1'b0;
      wdata_q     <= 8'd0;
      vid_rdata_q <= 8'd0;
      cpu_rdata_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      streak_q    <= streak_d;
      owner_cpu_q <= owner_cpu_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      vid_rdata_q <= vid_rdata_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  // Outputs decode registered state only; the final ACCESS cycle of a write
  // keeps we_n high so address and data are held past the strobe.
  assign busy         = (state_q != ST_IDLE);
  assign sram_addr    = addr_q;
  assign sram_dout    = wdata_q;
  assign sram_dout_en = we_q && (state_q != ST_IDLE);
  assign sram_we_n    = !((state_q == ST_ACCESS) && we_q && (cnt_q <= CNT_WE_LAST));
  assign vid_ack      = (state_q == ST_DONE) && !owner_cpu_q;
  assign cpu_ack      = (state_q == ST_DONE) && owner_cpu_q;
  assign vid_rdata    = vid_rdata_q;
  assign cpu_rdata    = cpu_rdata_q;

endmodule
